decode_stage: RTL and testbench
===============================

# decode_stage

- Parametrised, handshaked instruction decode stage for the multi-cycle RV32-subset core.
- Accepts one instruction per transaction, registers the decoded bundle, and then issues it as a sequence of per-instruction micro-steps to the execute sequencer.
- Extends the combinational decoder with:
  - sign-extended immediates
  - branch (BEQ/BNE) and logic (AND/OR) ops
  - valid/ready flow control, flush, and a sticky halt on illegal encodings
- Sits between instruction fetch and the execute/memory sequencer.

## Interface
Parameters:
- XLEN, 32, datapath/immediate width (≥32)
- STEP_W, 2, micro-step counter width; max steps per instruction = 2^STEP_W

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  abort current instruction, return to IDLE
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction address
- out_valid  out  1  decoded step valid
- out_ready  in  1  sequencer consumes step
- out_op  out  OP_W  decoded operation (package enum)
- out_rd / out_rs1 / out_rs2  out  5 each  register indices, 0 when unused by op
- out_imm  out  XLEN  sign-extended immediate, 0 when op has none
- out_pc  out  XLEN  registered in_pc
- out_step  out  STEP_W  current micro-step index
- out_last  out  1  current step is final step
- halted  out  1  illegal instruction seen; sticky

## Operation
- States:
  - IDLE: in_ready=1.
  - BUSY: holds the bundle and steps.
  - HALT: all handshakes dead.
- Accept = in_valid & in_ready. On accept, decode in_instr:
  - Legal: register the bundle, step=0, go BUSY.
  - Illegal: go HALT.
- Ops and step counts (package constants):
  - ADD/SUB/AND/OR (R-type): 2
  - ADDI: 2
  - LW: 3
  - SW: 2
  - LUI: 1
  - JAL: 2
  - BEQ/BNE: 2
- Immediates:
  - I-type: sext(instr[31:20])
  - S-type: sext({instr[31:25], instr[11:7]})
  - B-type: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})
  - J-type: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})
  - LUI: {instr[31:12], 12'b0}, sign-extended to XLEN
- Register fields follow use: rs2 only for R/S/B types; rd only for R/I/LUI/JAL. Unused fields are 0.
- Illegal: any opcode/funct3/funct7 combination not in the list. This includes instr = 0.
- BUSY step handling, on out_valid & out_ready:
  - Not last: step increments.
  - Last: the bundle retires.
- in_ready = IDLE | (BUSY & out_last & out_ready & ~flush). This allows back-to-back accept in the same cycle as the last step retires.
- flush (any state except HALT):
  - Next state IDLE, out_valid=0. Flush has priority over accept and step advance.
  - flush in HALT has no effect. Only rst_n leaves HALT.

## Timing
- Reset values:
  - state IDLE, in_ready=1, out_valid=0, halted=0
  - all out_* fields 0, out_step=0, out_last=0
- Latency: accept at edge t → out_valid=1, step 0 visible after edge t.
- A k-step instruction needs at least k cycles of out_ready.
- Bundle fields are stable while out_valid=1. Only out_step/out_last change between steps.
- Illegal accept at edge t → halted=1 and in_ready=0 after edge t. out_valid stays 0.
- Back-to-back: the new instruction's step 0 is presented the cycle after the previous last step retires. There are no bubbles.
- Reset asserted mid-instruction: immediate return to reset values; the bundle is discarded.
- out_ready=0 stalls indefinitely with no state change.

## Structure
- Package decode_pkg holds:
  - op enum (OP_W=4): NOP, ADD, SUB, AND, OR, ADDI, LW, SW, LUI, JAL, BEQ, BNE
  - opcode/funct3/funct7 constants and field ranges
  - per-op step-count function
- Sub-module decode_comb: pure combinational instr → {op, rd, rs1, rs2, imm, legal, nsteps}.
- decode_stage holds only the FSM, registers and handshake.

## Test plan
- ADD x3,x1,x2 (0x002081B3) with out_ready=1 → op=ADD, rd=3, rs1=1, rs2=2, imm=0. Steps 0,1 on consecutive cycles, out_last on step 1.
- ADDI x1,x0,-1 (0xFFF00093) → imm=0xFFFFFFFF, rs2=0, 2 steps. LUI x7,0xABCDE (0xABCDE3B7) → imm=0xABCDE000, single step with out_last=1.
- LW x5,8(x2) (0x00812283) with out_ready low 2 cycles per step → 3 steps, bundle stable throughout, in_ready=0 until step 2 retires.
- BEQ x1,x2,+8 (0x00208463) followed immediately by SW x5,12(x2) (0x00512623) → SW accepted on BEQ's last step, no bubble. SW imm=12, rs1=2, rs2=5, rd=0.
- flush during LW step 1 → out_valid=0 next cycle, in_ready=1. The next instruction decodes normally.
- in_instr=0x00000000 → halted=1, in_ready=0, out_valid=0 permanently. Toggling flush has no effect. rst_n low clears halted.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: shared definitions for the RV32-subset decode stage.
// Holds the decoded-operation enum, the stage FSM state enum, RV32
// opcode/funct constants, instruction field positions and the per-op
// micro-step count.
package decode_pkg;

  localparam int OP_W     = 4;
  localparam int NSTEPS_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI,
    OP_LW, OP_SW, OP_LUI, OP_JAL, OP_BEQ, OP_BNE
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE, S_BUSY, S_HALT
  } state_e;

  // Major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // funct3 / funct7 values
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Field positions (LSB of each field)
  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int F7_LSB  = 25;

  localparam logic [NSTEPS_W-1:0] ONE_STEP = NSTEPS_W'(1);

  // Number of micro-steps the execute sequencer needs for each op.
  function automatic logic [NSTEPS_W-1:0] op_steps(input op_e op);
    case (op)
      OP_NOP:  op_steps = NSTEPS_W'(0);
      OP_LW:   op_steps = NSTEPS_W'(3);
      OP_LUI:  op_steps = NSTEPS_W'(1);
      default: op_steps = NSTEPS_W'(2);
    endcase
  endfunction

endpackage

// File: rtl/decode_comb.sv
// decode_comb: purely combinational RV32-subset decoder.
// Ports:
//   instr_i  : 32-bit instruction word
//   op_o     : decoded operation (OP_NOP when illegal)
//   rd_o/rs1_o/rs2_o : register indices, 0 when the op does not use them
//   imm_o    : sign-extended immediate, 0 when the op has none
//   legal_o  : encoding is one of the supported instructions
//   nsteps_o : micro-step count for the op
module decode_comb
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]          instr_i,
  output op_e                  op_o,
  output logic [4:0]           rd_o,
  output logic [4:0]           rs1_o,
  output logic [4:0]           rs2_o,
  output logic [XLEN-1:0]      imm_o,
  output logic                 legal_o,
  output logic [NSTEPS_W-1:0]  nsteps_o
);

  logic [6:0]        opc;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic              use_rd, use_rs1, use_rs2;
  logic signed [31:0] imm32;

  assign opc = instr_i[6:0];
  assign f3  = instr_i[F3_LSB +: 3];
  assign f7  = instr_i[F7_LSB +: 7];

  always_comb begin
    op_o    = OP_NOP;
    legal_o = 1'b0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    imm32   = '0;
    case (opc)
      OPC_OP: begin
        legal_o = 1'b1;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        if (f3 == F3_ADD && f7 == F7_BASE)      op_o = OP_ADD;
        else if (f3 == F3_ADD && f7 == F7_ALT)  op_o = OP_SUB;
        else if (f3 == F3_AND && f7 == F7_BASE) op_o = OP_AND;
        else if (f3 == F3_OR && f7 == F7_BASE)  op_o = OP_OR;
        else legal_o = 1'b0;
      end
      OPC_OPIMM, OPC_LOAD: begin
        if ((opc == OPC_OPIMM && f3 == F3_ADD) || (opc == OPC_LOAD && f3 == F3_WORD)) begin
          op_o    = (opc == OPC_OPIMM) ? OP_ADDI : OP_LW;
          legal_o = 1'b1;
          use_rd  = 1'b1;
          use_rs1 = 1'b1;
          imm32   = {{20{instr_i[31]}}, instr_i[31:20]};
        end
      end
      OPC_STORE: begin
        if (f3 == F3_WORD) begin
          op_o    = OP_SW;
          legal_o = 1'b1;
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
          imm32   = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
        end
      end
      OPC_LUI: begin
        op_o    = OP_LUI;
        legal_o = 1'b1;
        use_rd  = 1'b1;
        imm32   = {instr_i[31:12], 12'b0};
      end
      OPC_JAL: begin
        op_o    = OP_JAL;
        legal_o = 1'b1;
        use_rd  = 1'b1;
        imm32   = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                   instr_i[30:21], 1'b0};
      end
      OPC_BRANCH: begin
        if (f3 == F3_BEQ || f3 == F3_BNE) begin
          op_o    = (f3 == F3_BEQ) ? OP_BEQ : OP_BNE;
          legal_o = 1'b1;
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
          imm32   = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                     instr_i[11:8], 1'b0};
        end
      end
      default: ;
    endcase
  end

  assign rd_o     = use_rd  ? instr_i[RD_LSB  +: 5] : 5'd0;
  assign rs1_o    = use_rs1 ? instr_i[RS1_LSB +: 5] : 5'd0;
  assign rs2_o    = use_rs2 ? instr_i[RS2_LSB +: 5] : 5'd0;
  // Signed source: the size cast sign-extends to XLEN.
  assign imm_o    = XLEN'(imm32);
  assign nsteps_o = op_steps(op_o);

endmodule

// File: rtl/decode_stage.sv
// decode_stage: handshaked decode stage. Accepts one instruction from
// fetch, registers the decoded bundle and presents it to the execute
// sequencer as a sequence of micro-steps. Illegal encodings halt the
// stage until reset.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   flush                    : abort current instruction (ignored in HALT)
//   in_valid/in_ready        : fetch handshake; in_instr, in_pc payload
//   out_valid/out_ready      : sequencer handshake, one step per transfer
//   out_op/rd/rs1/rs2/imm/pc : registered decoded bundle
//   out_step, out_last       : current micro-step index, final-step flag
//   halted                   : sticky illegal-instruction flag
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STEP_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output op_e               out_op,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_pc,
  output logic [STEP_W-1:0] out_step,
  output logic              out_last,
  output logic              halted
);

  op_e                 dec_op;
  logic [4:0]          dec_rd, dec_rs1, dec_rs2;
  logic [XLEN-1:0]     dec_imm;
  logic                dec_legal;
  logic [NSTEPS_W-1:0] dec_nsteps;

  decode_comb #(.XLEN(XLEN)) u_dec (
    .instr_i  (in_instr),
    .op_o     (dec_op),
    .rd_o     (dec_rd),
    .rs1_o    (dec_rs1),
    .rs2_o    (dec_rs2),
    .imm_o    (dec_imm),
    .legal_o  (dec_legal),
    .nsteps_o (dec_nsteps)
  );

  state_e              state_q, state_d;
  op_e                 op_q;
  logic [4:0]          rd_q, rs1_q, rs2_q;
  logic [XLEN-1:0]     imm_q, pc_q;
  logic [STEP_W-1:0]   step_q, last_idx_q;
  logic                is_last, accept, step_fire;

  assign is_last = (step_q == last_idx_q);
  // in_ready can be high in IDLE while flush is asserted; flush still wins.
  assign accept    = in_valid & in_ready & ~flush;
  assign step_fire = out_valid & out_ready & ~flush;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!flush && in_valid) state_d = dec_legal ? S_BUSY : S_HALT;
      end
      S_BUSY: begin
        if (flush) state_d = S_IDLE;
        else if (out_ready && is_last) begin
          // Retiring the last step: pick up the next instruction in the same cycle.
          if (in_valid) state_d = dec_legal ? S_BUSY : S_HALT;
          else          state_d = S_IDLE;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == S_IDLE) |
                ((state_q == S_BUSY) & is_last & out_ready & ~flush);
    out_valid = (state_q == S_BUSY);
    out_last  = (state_q == S_BUSY) & is_last;
    halted    = (state_q == S_HALT);
  end

  // Bundle and step counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OP_NOP;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      step_q     <= '0;
      last_idx_q <= '0;
    end else if (accept && dec_legal) begin
      op_q       <= dec_op;
      rd_q       <= dec_rd;
      rs1_q      <= dec_rs1;
      rs2_q      <= dec_rs2;
      imm_q      <= dec_imm;
      pc_q       <= in_pc;
      step_q     <= '0;
      last_idx_q <= STEP_W'(dec_nsteps - ONE_STEP);
    end else if (step_fire && !is_last) begin
      step_q <= step_q + STEP_W'(1);
    end else if (step_fire || flush) begin
      step_q <= '0;
    end
  end

  assign out_op   = op_q;
  assign out_rd   = rd_q;
  assign out_rs1  = rs1_q;
  assign out_rs2  = rs2_q;
  assign out_imm  = imm_q;
  assign out_pc   = pc_q;
  assign out_step = step_q;

endmodule

// File: tb/tb_decode_stage.sv
`timescale 1ns/1ps
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_imm, out_pc;
  logic [3:0]  out_op;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [1:0]  out_step;
  logic        out_last, halted;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .STEP_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_pc(out_pc), .out_step(out_step), .out_last(out_last), .halted(halted)
  );

  // Op encodings: NOP=0 ADD=1 SUB=2 AND=3 OR=4 ADDI=5 LW=6 SW=7 LUI=8 JAL=9 BEQ=10 BNE=11
  typedef struct {
    logic [31:0] instr;
    logic [3:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    int          steps;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'h002081B3, 4'd1,  5'd3, 5'd1, 5'd2, 32'h0000_0000, 2}; // add x3,x1,x2
    vecs[1]  = '{32'h402081B3, 4'd2,  5'd3, 5'd1, 5'd2, 32'h0000_0000, 2}; // sub
    vecs[2]  = '{32'h0020F1B3, 4'd3,  5'd3, 5'd1, 5'd2, 32'h0000_0000, 2}; // and
    vecs[3]  = '{32'h0020E1B3, 4'd4,  5'd3, 5'd1, 5'd2, 32'h0000_0000, 2}; // or
    vecs[4]  = '{32'hFFF00093, 4'd5,  5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 2}; // addi x1,x0,-1
    vecs[5]  = '{32'h00812283, 4'd6,  5'd5, 5'd2, 5'd0, 32'h0000_0008, 3}; // lw x5,8(x2)
    vecs[6]  = '{32'h00512623, 4'd7,  5'd0, 5'd2, 5'd5, 32'h0000_000C, 2}; // sw x5,12(x2)
    vecs[7]  = '{32'hABCDE3B7, 4'd8,  5'd7, 5'd0, 5'd0, 32'hABCD_E000, 1}; // lui x7,0xABCDE
    vecs[8]  = '{32'hFFDFF0EF, 4'd9,  5'd1, 5'd0, 5'd0, 32'hFFFF_FFFC, 2}; // jal x1,-4
    vecs[9]  = '{32'h00208463, 4'd10, 5'd0, 5'd1, 5'd2, 32'h0000_0008, 2}; // beq x1,x2,+8
    vecs[10] = '{32'h00209463, 4'd11, 5'd0, 5'd1, 5'd2, 32'h0000_0008, 2}; // bne x1,x2,+8

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_out_op", 32'(out_op), 32'd0);
    chk("rst_out_imm", out_imm, 32'd0);
    chk("rst_out_step", 32'(out_step), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Table-driven single-instruction vectors, out_ready held high
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_instr = vecs[i].instr; in_pc = 32'h100 + 32'(i * 4);
      #1 chk("vec_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("vec_op", 32'(out_op), 32'(vecs[i].op));
      chk("vec_rd", 32'(out_rd), 32'(vecs[i].rd));
      chk("vec_rs1", 32'(out_rs1), 32'(vecs[i].rs1));
      chk("vec_rs2", 32'(out_rs2), 32'(vecs[i].rs2));
      chk("vec_imm", out_imm, vecs[i].imm);
      chk("vec_pc", out_pc, 32'h100 + 32'(i * 4));
      for (int k = 0; k < vecs[i].steps; k++) begin
        chk("vec_valid", 32'(out_valid), 32'd1);
        chk("vec_step", 32'(out_step), 32'(k));
        chk("vec_last", 32'(out_last), 32'(k == vecs[i].steps - 1));
        @(negedge clk); #1;
      end
      chk("vec_retired", 32'(out_valid), 32'd0);
    end

    // LW with out_ready low for two cycles per step
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h00812283; in_pc = 32'h200; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      for (int r = 0; r < 2; r++) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_step", 32'(out_step), 32'(s));
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_op", 32'(out_op), 32'd6);
        chk("stall_imm", out_imm, 32'd8);
        chk("stall_rd", 32'(out_rd), 32'd5);
        @(negedge clk); #1;
      end
      out_ready = 1'b1;
      #1;
      chk("stall_in_ready_fire", 32'(in_ready), 32'(s == 2));
      chk("stall_last", 32'(out_last), 32'(s == 2));
      @(negedge clk);
      out_ready = 1'b0;
      #1;
    end
    chk("stall_retired", 32'(out_valid), 32'd0);
    out_ready = 1'b1;

    // BEQ followed back-to-back by SW
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h00208463; in_pc = 32'h300;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("b2b_beq_op", 32'(out_op), 32'd10);
    chk("b2b_beq_step0", 32'(out_step), 32'd0);
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h00512623; in_pc = 32'h304;
    #1;
    chk("b2b_beq_last", 32'(out_last), 32'd1);
    chk("b2b_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("b2b_sw_valid", 32'(out_valid), 32'd1);
    chk("b2b_sw_op", 32'(out_op), 32'd7);
    chk("b2b_sw_step", 32'(out_step), 32'd0);
    chk("b2b_sw_imm", out_imm, 32'd12);
    chk("b2b_sw_rs1", 32'(out_rs1), 32'd2);
    chk("b2b_sw_rs2", 32'(out_rs2), 32'd5);
    chk("b2b_sw_rd", 32'(out_rd), 32'd0);
    chk("b2b_sw_pc", out_pc, 32'h304);
    @(negedge clk); #1;
    chk("b2b_sw_step1", 32'(out_step), 32'd1);
    chk("b2b_sw_last", 32'(out_last), 32'd1);
    @(negedge clk); #1;
    chk("b2b_idle", 32'(out_valid), 32'd0);

    // Flush during LW step 1, then a normal ADD
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h00812283; in_pc = 32'h400;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_step1", 32'(out_step), 32'd1);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h500;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("post_flush_op", 32'(out_op), 32'd1);
    chk("post_flush_rd", 32'(out_rd), 32'd3);
    chk("post_flush_step", 32'(out_step), 32'd0);
    @(negedge clk); #1;
    chk("post_flush_last", 32'(out_last), 32'd1);
    @(negedge clk); #1;
    chk("post_flush_idle", 32'(out_valid), 32'd0);

    // Reset asserted mid-instruction
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h00812283; in_pc = 32'h600;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_op", 32'(out_op), 32'd0);
    chk("midrst_imm", out_imm, 32'd0);
    chk("midrst_pc", out_pc, 32'd0);
    chk("midrst_step", 32'(out_step), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;

    // Illegal encodings: all-zero word and MUL (funct7=0000001)
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      in_valid = 1'b1; in_instr = (j == 0) ? 32'h00000000 : 32'h022081B3;
      #1 chk("ill_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      #1;
      chk("ill_halted", 32'(halted), 32'd1);
      chk("ill_in_ready_after", 32'(in_ready), 32'd0);
      chk("ill_out_valid", 32'(out_valid), 32'd0);
      in_instr = 32'h002081B3;
      for (int t = 0; t < 4; t++) begin
        flush = (t % 2 == 0);
        @(negedge clk); #1;
        chk("ill_sticky_halted", 32'(halted), 32'd1);
        chk("ill_sticky_ready", 32'(in_ready), 32'd0);
        chk("ill_sticky_valid", 32'(out_valid), 32'd0);
      end
      flush = 1'b0; in_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("ill_rst_halted", 32'(halted), 32'd0);
      chk("ill_rst_ready", 32'(in_ready), 32'd1);
      @(negedge clk); rst_n = 1'b1;
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
